// File: rtl/ws281x_pkg.sv
// ws281x_pkg: shared state encoding, default 20 MHz timing and parameter checks
// for the ws281x_tx multi-string pixel transmitter.
package ws281x_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    BIT      = 2'd2,
    LATCH    = 2'd3
  } state_t;

  // Default timing for a 20 MHz pixel clock (50 ns per cycle)
  localparam int DEF_T0H    = 5;
  localparam int DEF_T1H    = 20;
  localparam int DEF_TBIT   = 25;
  localparam int DEF_TRESET = 1000;

  // True when the bit timing is ordered and the pixel width is RGB or RGBW
  function automatic bit cfg_ok(input int bpp, input int t0h, input int t1h, input int tbit);
    return (t0h < t1h) && (t1h < tbit) && ((bpp == 24) || (bpp == 32));
  endfunction

  // Counter width for a range of n values, never below one bit
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ws281x_chan.sv
// ws281x_chan: one LED string. Holds the pixel shift register, the optional
// brightness scaling in the load path (WS281X_BRIGHT_EN) and the registered
// high/low comparator that shapes each bit.
module ws281x_chan
  import ws281x_pkg::*;
#(
  parameter int BPP = 24,
  parameter int CW  = 5,
  parameter int T0H = DEF_T0H,
  parameter int T1H = DEF_T1H
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           shift,
  input  logic           active,
  input  logic [CW-1:0]  cnt,
  input  logic [BPP-1:0] data_in,
`ifdef WS281X_BRIGHT_EN
  input  logic [7:0]     bright,
`endif
  output logic           tx
);

  localparam logic [CW-1:0] T0H_C = CW'(T0H);
  localparam logic [CW-1:0] T1H_C = CW'(T1H);

  logic [BPP-1:0] shreg;
  logic [BPP-1:0] load_word;
  logic           msb;
  logic [CW-1:0]  thr;

`ifdef WS281X_BRIGHT_EN
  // Scale every 8-bit field by (bright+1)/256; bright=255 is identity
  function automatic logic [BPP-1:0] scale_word(input logic [BPP-1:0] w, input logic [7:0] b);
    logic [BPP-1:0] r;
    logic [16:0]    f;
    logic [16:0]    m;
    logic [16:0]    p;
    r = '0;
    m = {9'd0, b} + 17'd1;
    for (int i = 0; i < BPP / 8; i++) begin
      f = {9'd0, w[i*8 +: 8]};
      p = f * m;
      r[i*8 +: 8] = p[15:8];
    end
    return r;
  endfunction

  // Brightness-scaled word presented to the shift register at load time
  always_comb begin
    load_word = scale_word(data_in, bright);
  end
`else
  // Word presented to the shift register at load time, unmodified
  always_comb begin
    load_word = data_in;
  end
`endif

  // Current bit: the freshly loaded word's MSB on the load cycle, else the register's
  always_comb begin
    msb = load ? load_word[BPP-1] : shreg[BPP-1];
    thr = msb ? T1H_C : T0H_C;
  end

  // Shift register (MSB first) and registered serial output
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      tx    <= 1'b0;
    end else begin
      if (load) begin
        shreg <= load_word;
      end else if (shift) begin
        shreg <= {shreg[BPP-2:0], 1'b0};
      end
      tx <= active & (cnt < thr);
    end
  end

endmodule

// File: rtl/ws281x_tx.sv
// ws281x_tx: multi-channel WS281x transmitter top. FSM, bit/cycle/latch
// counters and pixel RAM address generation; one ws281x_chan per string.
// Optional feature macro: WS281X_BRIGHT_EN adds the bright[7:0] input.
module ws281x_tx
  import ws281x_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int BPP    = 24,
  parameter int ADDR_W = 8,
  parameter int T0H    = DEF_T0H,
  parameter int T1H    = DEF_T1H,
  parameter int TBIT   = DEF_TBIT,
  parameter int TRESET = DEF_TRESET
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base,
  input  logic [ADDR_W:0]    leds,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [NCH*BPP-1:0] rd_data,
`ifdef WS281X_BRIGHT_EN
  input  logic [7:0]         bright,
`endif
  output logic [NCH-1:0]     tx_out
);

  localparam int CW = cw(TBIT);
  localparam int BW = cw(BPP);
  localparam int LW = cw(TRESET);
  localparam int RW = ADDR_W + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(TBIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BPP - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(TRESET - 1);

  if (!cfg_ok(BPP, T0H, T1H, TBIT) || (NCH < 1) || (NCH > 16)) begin : g_cfg_err
    $error("ws281x_tx: invalid timing, pixel width or channel count");
  end

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [BW-1:0]      bit_idx, bit_nx;
  logic [LW-1:0]      lat_cnt, lat_nx;
  logic [RW-1:0]      remaining, rem_nx;
  logic [ADDR_W-1:0]  addr_nx;
  logic               busy_nx, done_nx;
  logic               load, shift, active;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, counter updates and per-string load/shift strobes
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    lat_nx   = lat_cnt;
    rem_nx   = remaining;
    addr_nx  = rd_addr;
    busy_nx  = busy;
    done_nx  = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    active   = 1'b0;
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        // A start coinciding with the done pulse is dropped
        if (start && !done) begin
          addr_nx = base;
          rem_nx  = leds;
          if (leds == '0) begin
            done_nx = 1'b1;
          end else begin
            busy_nx  = 1'b1;
            state_nx = PREFETCH;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      PREFETCH: begin
        cnt_nx   = '0;
        bit_nx   = '0;
        state_nx = BIT;
      end
      BIT: begin
        active = 1'b1;
        // Load at the very start of each pixel; the next address then has a whole pixel to settle
        load = (cnt == '0) && (bit_idx == '0);
        if (load) begin
          addr_nx = rd_addr + ADDR_W'(1);
        end else begin
          addr_nx = rd_addr;
        end
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          shift  = 1'b1;
          if (bit_idx == BIT_LAST) begin
            bit_nx = '0;
            rem_nx = remaining - RW'(1);
            if (remaining == RW'(1)) begin
              lat_nx   = '0;
              state_nx = LATCH;
            end else begin
              state_nx = BIT;
            end
          end else begin
            bit_nx = bit_idx + BW'(1);
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      LATCH: begin
        if (lat_cnt == LAT_LAST) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          lat_nx = lat_cnt + LW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath registers: counters, address and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      lat_cnt   <= '0;
      remaining <= '0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      bit_idx   <= bit_nx;
      lat_cnt   <= lat_nx;
      remaining <= rem_nx;
      rd_addr   <= addr_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    ws281x_chan #(
      .BPP (BPP),
      .CW  (CW),
      .T0H (T0H),
      .T1H (T1H)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift   (shift),
      .active  (active),
      .cnt     (cnt),
      .data_in (rd_data[k*BPP +: BPP]),
`ifdef WS281X_BRIGHT_EN
      .bright  (bright),
`endif
      .tx      (tx_out[k])
    );
  end

endmodule

// File: doc/ws281x_tx.md
# ws281x_tx

Parametrised multi-channel WS281x-family pixel transmitter. Streams pixel words from an external single-clock pixel RAM and drives NCH LED strings in lockstep, one serial output each. Bit timing and reset length are parameters, and pixel width is 24 or 32 bits (RGB/RGBW). Sits between the host-written frame buffer and the LED output pins, and replaces the fixed 24-bit, single-string driver.

## Interface
Parameters:
- NCH, 4 — number of parallel strings (1..16)
- BPP, 24 — bits per pixel per channel (24 or 32)
- ADDR_W, 8 — pixel RAM address width; a frame holds up to 2^ADDR_W pixels
- T0H, 5 — high cycles for a 0 bit (250 ns at 20 MHz)
- T1H, 20 — high cycles for a 1 bit
- TBIT, 25 — total cycles per bit; requires T0H < T1H < TBIT
- TRESET, 1000 — low latch cycles after the frame (50 µs)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle frame request
- base  in  ADDR_W  first pixel address, sampled with start
- leds  in  ADDR_W+1  pixels per string, 0..2^ADDR_W, sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse when the frame and latch period are complete
- rd_addr  out  ADDR_W  pixel RAM read address
- rd_data  in  NCH*BPP  RAM data, valid 1 cycle after rd_addr; channel k is at [k*BPP +: BPP]
- tx_out  out  NCH  serial outputs, registered

## Operation
- States: IDLE, PREFETCH, BIT, LATCH.
- IDLE: tx_out=0, busy=0. start samples base and leds and drives rd_addr<=base.
  - leds≠0: go to PREFETCH.
  - leds==0: pulse done on the next cycle and stay in IDLE. No pulses, no latch period.
- PREFETCH: lasts 1 cycle and then enters BIT with bit index 0 and cycle counter cnt 0.
- BIT, cnt==0 of bit 0: each channel's shift register loads rd_data, and rd_addr increments. The next pixel is therefore ready long before it is needed.
- BIT, waveform: tx_out[k] is high while cnt < (shift_k MSB ? T1H : T0H), else low.
  - cnt counts 0..TBIT-1.
  - At cnt==TBIT-1 the shift registers shift left by 1 and the bit index increments.
- End of pixel: after bit BPP-1, decrement the remaining-pixel count.
  - Count nonzero: next pixel starts at bit 0 with no gap.
  - Count zero: go to LATCH.
- LATCH: tx_out=0 for TRESET cycles. done pulses on the last LATCH cycle, then return to IDLE.
- Bits are sent MSB first. Colour byte order is the host's responsibility.
- rd_addr wraps modulo 2^ADDR_W. For example, base=0xFF with leds=2 reads 0xFF then 0x00.
- start while busy is ignored, as is start in the same cycle as done.
- rst mid-frame: on the next edge tx_out=0, busy=0, done=0, rd_addr=0, state IDLE. No latch period is generated.

## Timing
- Reset values: tx_out=0, busy=0, done=0, rd_addr=0.
- First rising edge of tx_out occurs 2 cycles after start is sampled (PREFETCH + load).
- Frame length from the start sample to the done pulse: 1 + 1 + leds×BPP×TBIT + TRESET cycles.
- All NCH outputs switch on the same clock edge.
- rd_addr is stable for at least TBIT×BPP−1 cycles before its data is loaded.
- Counter widths: cnt is clog2(TBIT) bits, the bit index is clog2(BPP) bits, and the latch counter is clog2(TRESET) bits.

## Configuration
- WS281X_BRIGHT_EN defined:
  - adds input port bright [7:0];
  - each 8-bit field of every channel word is replaced by (field×(bright+1))>>8 when the shift register loads;
  - bright=255 gives identity; bright=0 gives 0 for all fields;
  - bright is sampled per pixel load;
  - no latency change (the multiply sits in the load path, or in one pipeline register during PREFETCH and the prefetch window).
- Not defined: no bright port, and words are sent unmodified.

## Structure
- Package ws281x_pkg holds:
  - the state enum (IDLE, PREFETCH, BIT, LATCH);
  - default timing constants for 20 MHz;
  - a width-check function enforcing T0H<T1H<TBIT and BPP∈{24,32}.
- Sub-module ws281x_chan, one instance per channel, holds:
  - the BPP shift register;
  - the optional brightness scaling;
  - the output comparator (cnt vs T0H/T1H).
- The top level holds the FSM, counters and address generation.

## Test plan
- NCH=2, BPP=24, leds=1, ch0=0xFF0000, ch1=0x000001:
  - ch0 gives 8 pulses of 20 high cycles, then 16 of 5;
  - ch1 gives 23 pulses of 5 high, then 1 of 20;
  - done arrives 1+1+600+1000 cycles after start.
- base=0xFE, leds=3 → rd_addr sequence 0xFE, 0xFF, 0x00; three pixels with no inter-pixel gap.
- leds=0 → done pulse 1 cycle after start, busy stays 0, tx_out stays 0.
- start pulsed again mid-frame → ignored; frame length unchanged; exactly one done.
- rst asserted mid-bit while tx_out is high → tx_out=0 and busy=0 on the next edge; a new start afterwards runs a clean frame.
- BPP=32 with WS281X_BRIGHT_EN defined, bright=127, word 0xFF80_4002 → transmitted word 0x7F40_2001.
